// File: rtl/enetseq_pkg.sv
// Shared definitions for the Ethernet TX nibble sequencer: FSM states,
// default frame-length constants and the nibble counter width.
package enetseq_pkg;

  localparam int CNT_W           = 12;
  localparam int MIN_NIBBLES_DEF = 120;
  localparam int MAX_NIBBLES_DEF = 3028;
  localparam int CRC_NIBBLES_DEF = 8;
  localparam int IPG_NIBBLES_DEF = 24;

  typedef enum logic [2:0] {
    IDLE,
    BODY,
    DRAIN,
    PAD,
    CRC,
    IPG
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/enetseq_timer.sv
// Loadable, ce-gated down-counter with a zero flag; times the CRC tail and
// the inter-packet gap of the TX sequencer.
module enetseq_timer
  import enetseq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_ce,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_ce) begin
      if (i_load) begin
        cnt_d = i_load_val;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/enetseq_tx.sv
// Ethernet TX frame sequencer: serializes source bytes low nibble first into the
// CRC appender, waits out the CRC tail and the IPG. Short-frame padding: ENETSEQ_PAD_EN.
module enetseq_tx
  import enetseq_pkg::*;
#(
  parameter int MIN_NIBBLES = MIN_NIBBLES_DEF,
  parameter int MAX_NIBBLES = MAX_NIBBLES_DEF,
  parameter int CRC_NIBBLES = CRC_NIBBLES_DEF,
  parameter int IPG_NIBBLES = IPG_NIBBLES_DEF
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic       i_crc_on,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_crc_v,
  output logic [3:0] o_crc_d,
  output logic       o_crc_en,
  output logic       o_crc_cancel,
  output logic       o_busy,
  output logic       o_err
);

  localparam logic [CNT_W-1:0] MinN  = CNT_W'(MIN_NIBBLES);
  localparam logic [CNT_W-1:0] MaxN  = CNT_W'(MAX_NIBBLES);
  localparam logic [CNT_W-1:0] CrcLd = CNT_W'(CRC_NIBBLES - 1);
  localparam logic [CNT_W-1:0] IpgLd = CNT_W'(IPG_NIBBLES - 1);
`ifdef ENETSEQ_PAD_EN
  localparam bit PadOn = 1'b1;
`else
  localparam bit PadOn = 1'b0;
`endif

  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic             crc_v_q, crc_v_d;
  logic [3:0]       nib_q, nib_d;
  logic             crc_en_q, crc_en_d;
  logic             cancel_q, cancel_d;
  logic             err_q, err_d;
  logic             abort;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  assign count_inc = sat_inc(count_q);

  // The accepting IDLE edge already emits the low nibble, so BODY resumes at phase 1.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    count_d  = count_q;
    crc_v_d  = crc_v_q;
    nib_d    = nib_q;
    crc_en_d = crc_en_q;
    cancel_d = cancel_q;
    err_d    = 1'b0;
    abort    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = IpgLd;
    if (i_ce) begin
      crc_v_d  = 1'b0;
      nib_d    = 4'h0;
      cancel_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            state_d  = BODY;
            phase_d  = 1'b1;
            count_d  = CNT_W'(1);
            crc_en_d = i_crc_on;
            crc_v_d  = 1'b1;
            nib_d    = i_data[3:0];
          end
        end
        BODY: begin
          if (!i_valid) begin
            abort = 1'b1;
          end else if (!phase_q) begin
            crc_v_d = 1'b1;
            nib_d   = i_data[3:0];
            phase_d = 1'b1;
            count_d = count_inc;
          end else if (!i_last && (count_inc >= MaxN)) begin
            abort = 1'b1;
          end else begin
            crc_v_d = 1'b1;
            nib_d   = i_data[7:4];
            phase_d = 1'b0;
            count_d = count_inc;
            if (i_last) begin
              if (PadOn && (count_inc < MinN)) begin
                state_d = PAD;
              end else begin
                state_d  = CRC;
                tmr_load = 1'b1;
                tmr_val  = CrcLd;
              end
            end
          end
        end
        DRAIN: begin
          // An empty source ends the drain as well as the frame's last byte.
          if (!i_valid || i_last) begin
            state_d  = IPG;
            tmr_load = 1'b1;
            tmr_val  = IpgLd;
          end
        end
`ifdef ENETSEQ_PAD_EN
        PAD: begin
          crc_v_d = 1'b1;
          count_d = count_inc;
          if (count_inc >= MinN) begin
            state_d  = CRC;
            tmr_load = 1'b1;
            tmr_val  = CrcLd;
          end
        end
`endif
        CRC: begin
          if (tmr_zero) begin
            state_d  = IPG;
            tmr_load = 1'b1;
            tmr_val  = IpgLd;
          end
        end
        IPG: begin
          if (tmr_zero) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (abort) begin
        state_d  = DRAIN;
        phase_d  = 1'b0;
        cancel_d = 1'b1;
        err_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      phase_q  <= 1'b0;
      count_q  <= '0;
      crc_v_q  <= 1'b0;
      nib_q    <= 4'h0;
      crc_en_q <= 1'b0;
      cancel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      count_q  <= count_d;
      crc_v_q  <= crc_v_d;
      nib_q    <= nib_d;
      crc_en_q <= crc_en_d;
      cancel_q <= cancel_d;
      err_q    <= err_d;
    end
  end

  enetseq_timer u_timer (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_ce       (i_ce),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_zero     (tmr_zero)
  );

  assign o_ready      = i_ce & (((state_q == BODY) & phase_q) | (state_q == DRAIN));
  assign o_crc_v      = crc_v_q;
  assign o_crc_d      = nib_q;
  assign o_crc_en     = crc_en_q;
  assign o_crc_cancel = cancel_q;
  assign o_busy       = (state_q != IDLE);
  assign o_err        = err_q;

endmodule

// File: tb/tb_enetseq_tx.sv
// Self-checking bench for enetseq_tx: random frames and ce patterns compared
// against a frame-level stream model of the expected per-ce-cycle outputs.
module tb_enetseq_tx;

  localparam int MIN_N  = 120;
  localparam int MAX_N  = 3028;
  localparam int CRC_N  = 8;
  localparam int IPG_N  = 24;
  localparam int BUDGET = 20000;
`ifdef ENETSEQ_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_reset_n;
  logic       i_ce, i_crc_on, i_valid, i_last;
  logic [7:0] i_data;
  logic       o_ready, o_crc_v, o_crc_en, o_crc_cancel, o_busy, o_err;
  logic [3:0] o_crc_d;

  always #5 clk = ~clk;

  enetseq_tx dut (
    .i_clk        (clk),
    .i_reset_n    (i_reset_n),
    .i_ce         (i_ce),
    .i_crc_on     (i_crc_on),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .o_crc_v      (o_crc_v),
    .o_crc_d      (o_crc_d),
    .o_crc_en     (o_crc_en),
    .o_crc_cancel (o_crc_cancel),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  typedef struct packed {
    logic       v;
    logic [3:0] d;
    logic       cancel;
    logic       busy;
    logic       en;
  } ent_t;

  typedef struct {
    logic [7:0] data;
    bit         last;
    bit         first;
    bit         crc;
    bit         drop;
  } src_t;

  src_t src_q[$];
  ent_t exp_q[$];
  ent_t obs_q[$];
  int   checks = 0, errors = 0, exp_ready = 0, exp_aborts = 0;

  function automatic ent_t mk(input logic v, input logic [3:0] d, input logic c,
                              input logic b, input logic e);
    mk = {v, d, c, b, e};
  endfunction

  function automatic ent_t sample();
    sample = {o_crc_v, o_crc_d, o_crc_cancel, o_busy, o_crc_en};
  endfunction

  // Queue a frame for the source and append its expected ce-cycle trace.
  // drop_at > 0: the source goes empty for one ce-cycle before byte drop_at.
  task automatic add_frame(input int n, input int drop_at, input bit crc, input bit ramp);
    logic [7:0] b[$];
    int nv, body, gap;
    bit abort;
    for (int i = 0; i < n; i++) begin
      logic [7:0] x;
      x = ramp ? 8'(i) : 8'($urandom);
      b.push_back(x);
      src_q.push_back('{data: x, last: (i == n - 1), first: (i == 0), crc: crc, drop: (i == drop_at)});
    end
    exp_ready += n;
    if (drop_at > 0 && drop_at < n) begin
      abort = 1'b1; nv = 2 * drop_at; body = drop_at;
    end else if (2 * n > MAX_N) begin
      abort = 1'b1; nv = MAX_N - 1; body = MAX_N / 2;
    end else begin
      abort = 1'b0; nv = 2 * n; body = n;
    end
    for (int i = 0; i < nv; i++) begin
      logic [7:0] x;
      x = b[i / 2];
      exp_q.push_back(mk(1'b1, (i % 2 == 1) ? x[7:4] : x[3:0], 1'b0, 1'b1, crc));
    end
    if (abort) begin
      exp_aborts++;
      exp_q.push_back(mk(1'b0, 4'h0, 1'b1, 1'b1, crc));
      for (int i = body; i < n; i++) exp_q.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, crc));
      gap = IPG_N;
    end else begin
      if (PAD_ON)
        for (int i = nv; i < MIN_N; i++) exp_q.push_back(mk(1'b1, 4'h0, 1'b0, 1'b1, crc));
      gap = CRC_N + IPG_N;
    end
    for (int i = 0; i < gap; i++) exp_q.push_back(mk(1'b0, 4'h0, 1'b0, (i != gap - 1), crc));
  endtask

  task automatic drive_src();
    if (src_q.size() == 0) begin
      i_valid = 1'b0; i_data = 8'h00; i_last = 1'b0; i_crc_on = 1'b0;
    end else begin
      i_valid  = !src_q[0].drop;
      i_data   = src_q[0].data;
      i_last   = src_q[0].last;
      i_crc_on = src_q[0].first ? src_q[0].crc : !src_q[0].crc;
    end
  endtask

  // mode 1: ce every clock, 4: every 4th clock, otherwise random ce.
  task automatic run(input int mode, input string name);
    int   cyc = 0, rdy = 0, errc = 0, holdv = 0, bad = -1, nmax;
    bit   done = 1'b0, ce_now, pop;
    ent_t cur, prev;
    logic [7:0] g, e;
    prev = sample();
    obs_q.delete();
    while (!done && cyc < BUDGET) begin
      case (mode)
        1:       ce_now = 1'b1;
        4:       ce_now = (cyc % 4 == 3);
        default: ce_now = ($urandom_range(2) != 0);
      endcase
      i_ce = ce_now;
      drive_src();
      @(negedge clk);
      pop = o_ready && i_valid;
      if (o_ready) rdy++;
      @(posedge clk);
      #1;
      if (pop) void'(src_q.pop_front());
      else if (ce_now && src_q.size() > 0 && src_q[0].drop) src_q[0].drop = 1'b0;
      if (o_err) errc++;
      cur = sample();
      if (ce_now) begin
        obs_q.push_back(cur);
        if (src_q.size() == 0 && !o_busy) done = 1'b1;
      end else if (cur !== prev) begin
        holdv++;
      end
      prev = cur;
      cyc++;
    end
    i_ce = 1'b0;
    drive_src();

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: still busy after %0d clocks, required idle", name, cyc);
    end
    nmax = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
    for (int i = 0; i < nmax; i++) begin
      if (i >= exp_q.size() || i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad = i;
        break;
      end
    end
    checks++;
    if (bad >= 0) begin
      g = (bad < obs_q.size()) ? obs_q[bad] : 8'hxx;
      e = (bad < exp_q.size()) ? exp_q[bad] : 8'hxx;
      errors++;
      $display("FAIL %s trace: ce-cycle %0d got {v,d,cancel,busy,en}=%h required %h (lengths %0d/%0d)",
               name, bad, g, e, obs_q.size(), exp_q.size());
    end
    checks++;
    if (rdy != exp_ready) begin
      errors++;
      $display("FAIL %s ready_count: got %0d required %0d", name, rdy, exp_ready);
    end
    checks++;
    if (errc != exp_aborts) begin
      errors++;
      $display("FAIL %s err_clocks: got %0d required %0d", name, errc, exp_aborts);
    end
    checks++;
    if (holdv != 0) begin
      errors++;
      $display("FAIL %s ce_low_hold: %0d output changes without ce, required 0", name, holdv);
    end
    exp_q.delete();
    exp_ready  = 0;
    exp_aborts = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_crc_v, o_crc_d, o_crc_cancel, o_crc_en, o_busy, o_err, o_ready} !== 10'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {o_crc_v, o_crc_d, o_crc_cancel, o_crc_en, o_busy, o_err, o_ready});
    end
    @(negedge clk);
    i_reset_n = 1'b1;
    i_ce      = 1'b1;
    @(posedge clk);
    #1;
    i_ce = 1'b0;
    checks++;
    if ({o_crc_v, o_busy, o_crc_cancel, o_err} !== 4'h0) begin
      errors++;
      $display("FAIL idle_no_valid: got %b required 0000", {o_crc_v, o_busy, o_crc_cancel, o_err});
    end
  endtask

  task automatic test_frame64();
    add_frame(64, -1, 1'b1, 1'b1);
    run(4, "frame64");
  endtask

  task automatic test_short_frame();
    add_frame(10, -1, 1'($urandom), 1'b0);
    run(2, "short10");
    add_frame(1, -1, 1'b1, 1'b0);
    run(2, "short1");
  endtask

  task automatic test_underrun();
    add_frame(20, 5, 1'b1, 1'b0);
    add_frame(16, -1, 1'b0, 1'b0);
    run(2, "underrun");
  endtask

  task automatic test_oversize();
    add_frame(1600, -1, 1'b1, 1'b0);
    run(1, "oversize");
  endtask

  task automatic test_max_frame();
    add_frame(MAX_N / 2, -1, 1'b0, 1'b0);
    run(2, "max_legal");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) add_frame($urandom_range(80, 1), -1, 1'($urandom), 1'b0);
    run(2, "back_to_back");
  endtask

  task automatic test_reset_mid();
    bit pop;
    add_frame(40, -1, 1'b1, 1'b0);
    exp_q.delete();
    exp_ready  = 0;
    exp_aborts = 0;
    for (int c = 0; c < 12; c++) begin
      i_ce = 1'b1;
      drive_src();
      @(negedge clk);
      pop = o_ready && i_valid;
      @(posedge clk);
      #1;
      if (pop) void'(src_q.pop_front());
    end
    checks++;
    if (o_busy !== 1'b1 || o_crc_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_body_state: busy=%b en=%b required 1 1", o_busy, o_crc_en);
    end
    #2;
    i_reset_n = 1'b0;
    #1;
    checks++;
    if ({o_crc_v, o_crc_d, o_crc_cancel, o_crc_en, o_busy, o_err, o_ready} !== 10'h0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %b required all zero",
               {o_crc_v, o_crc_d, o_crc_cancel, o_crc_en, o_busy, o_err, o_ready});
    end
    src_q.delete();
    i_ce = 1'b0;
    drive_src();
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
    @(posedge clk);
    #1;
    add_frame(12, -1, 1'b1, 1'b0);
    run(2, "after_reset");
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_ce      = 1'b0;
    i_crc_on  = 1'b0;
    i_valid   = 1'b0;
    i_data    = 8'h00;
    i_last    = 1'b0;
    test_reset();
    test_frame64();
    test_short_frame();
    test_underrun();
    test_oversize();
    test_max_frame();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
